cpu_controller_fsm: RTL and testbench
=====================================

// Module: cpu_controller_fsm
// PURPOSE
//  Moore FSM that sequences the simple-RISC datapath one instruction at a time.
//  Takes opcode/op from the instruction decoder and a start strobe 's'.
//  Drives the register-file selects, pipeline-register loads, mux selects and writeback.
//  Sits between the instruction register/decoder and the datapath in the cpu top level.
// PARAMETERS
//  VSEL_C      2'b00  vsel code: writeback source = C register
//  VSEL_PC     2'b01  vsel code: writeback source = PC (reserved, never driven here)
//  VSEL_IMM    2'b10  vsel code: writeback source = sximm8
//  VSEL_MDATA  2'b11  vsel code: writeback source = mdata (reserved, never driven here)
// PORTS
//  clk     in   1  rising-edge clock
//  reset   in   1  asynchronous, active-high; forces state WAIT
//  s       in   1  start; sampled only in WAIT
//  opcode  in   3  instruction[15:13]; held stable while w=0
//  op      in   2  instruction[12:11]; held stable while w=0
//  w       out  1  1 = idle in WAIT, ready for a new instruction
//  nsel    out  3  one-hot register select: [2]=Rn, [1]=Rd, [0]=Rm; 000 = none
//  loada   out  1  load A register
//  loadb   out  1  load B register
//  loadc   out  1  load C register
//  loads   out  1  load status flags
//  asel    out  1  1 = ALU A input forced to 0
//  bsel    out  1  1 = ALU B input = sximm5 (always 0 in this block)
//  vsel    out  2  writeback mux select, see parameters
//  write   out  1  register-file write enable
//  err     out  1  one-cycle pulse: unsupported opcode/op
// BEHAVIOUR
//  - All outputs are pure functions of state (Moore); no input-to-output combinational path.
//  - Reset value (async assert, and whenever in WAIT): w=1; every other output 0;
//    vsel=VSEL_C; nsel=000.
//  - States and outputs (outputs not listed are 0, nsel=000, vsel=VSEL_C):
//    WAIT       w=1
//    DECODE     none
//    GET_A      nsel=100, loada=1
//    GET_B      nsel=001, loadb=1
//    ALU        asel=(MOV-reg or MVN), loadc=1
//    CMP        loads=1
//    WRITE_REG  nsel=010, vsel=VSEL_C, write=1
//    WRITE_IMM  nsel=100, vsel=VSEL_IMM, write=1
//    ERR        err=1
//  - Transitions:
//    WAIT  -> DECODE if s=1, else stay
//    DECODE: 110/10 (MOV Rn,#imm8) -> WRITE_IMM
//            110/00 (MOV Rd,Rm,sh) -> GET_B
//            101/11 (MVN)          -> GET_B
//            101/00,01,10 (ADD,CMP,AND) -> GET_A
//            any other opcode/op   -> ERR
//    GET_A -> GET_B
//    GET_B -> CMP if 101/01, else ALU
//    ALU   -> WRITE_REG
//    WRITE_REG, WRITE_IMM, CMP, ERR -> WAIT
//  - Latency, counted as rising edges from the edge that samples s=1 to the edge that
//    restores w=1:
//    MOV imm 3; MOV reg 5; MVN 5; CMP 5; ADD/AND 6; illegal 3.
//  - s=1 on the cycle w returns to 1 starts the next instruction immediately.
//    WAIT is one cycle long, with no idle bubble.
//  - s is ignored outside WAIT.
//  - opcode/op changing mid-instruction is a usage error. Decode uses values sampled
//    in DECODE and GET_B; no protection is provided.
//  - Reset mid-instruction aborts immediately. No write or loads is issued after reset
//    asserts; the partially loaded A/B/C contents are left as-is.
//  - Exactly one write pulse per MOV/ADD/AND/MVN; zero for CMP and illegal.
//  - Unused state encodings fall to WAIT on the next edge.
// TESTING
//  - Reset with s=0: w=1, write=0, nsel=000 throughout; deassert reset and hold
//    s=0 for 10 cycles -> stays in WAIT.
//  - MOV R3,#-5 (opcode 110, op 10), s pulsed 1 cycle -> write=1 with nsel=100 and
//    vsel=10 in cycle 2 only; w=1 after 3 edges.
//  - ADD (101/00) -> sequence loada(nsel=100), loadb(nsel=001), loadc(asel=0),
//    write(nsel=010, vsel=00); w=1 after 6 edges; exactly 1 write.
//  - CMP (101/01) -> loada, loadb, then loads=1 one cycle; write never 1; w=1 after 5 edges.
//  - MOV reg (110/00) then MVN (101/11) back-to-back with s held 1 -> asel=1 in each ALU
//    state; no WAIT gap beyond 1 cycle; 2 writes total.
//  - opcode 111 -> err=1 for exactly one cycle, no loads/write; reset asserted in GET_B
//    of an ADD -> async return to WAIT, no write pulse.

Source files
------------

// File: rtl/cpu_controller_fsm.sv
// Moore controller that steps the simple-RISC datapath through one instruction at a time.
// Every datapath control is decoded from the registered state alone, so no input reaches an output combinationally.
module cpu_controller_fsm #(
  parameter logic [1:0] VSEL_C     = 2'b00,
  parameter logic [1:0] VSEL_PC    = 2'b01,
  parameter logic [1:0] VSEL_IMM   = 2'b10,
  parameter logic [1:0] VSEL_MDATA = 2'b11
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       s,
  input  logic [2:0] opcode,
  input  logic [1:0] op,
  output logic       w,
  output logic [2:0] nsel,
  output logic       loada,
  output logic       loadb,
  output logic       loadc,
  output logic       loads,
  output logic       asel,
  output logic       bsel,
  output logic [1:0] vsel,
  output logic       write,
  output logic       err,
  output logic [3:0] dbg_state,
  output logic       dbg_vsel_reserved
);

  typedef enum logic [3:0] {
    S_WAIT      = 4'd0,
    S_DECODE    = 4'd1,
    S_GET_A     = 4'd2,
    S_GET_B     = 4'd3,
    S_ALU       = 4'd4,
    S_CMP       = 4'd5,
    S_WRITE_REG = 4'd6,
    S_WRITE_IMM = 4'd7,
    S_ERR       = 4'd8
  } state_t;

  state_t r_state;
  state_t w_next;
  logic   r_zero_a;
  logic   w_is_mov_imm;
  logic   w_is_mov_reg;
  logic   w_is_mvn;
  logic   w_is_alu3;
  logic   w_is_cmp;

  assign w_is_mov_imm = (opcode == 3'b110) && (op == 2'b10);
  assign w_is_mov_reg = (opcode == 3'b110) && (op == 2'b00);
  assign w_is_mvn     = (opcode == 3'b101) && (op == 2'b11);
  assign w_is_cmp     = (opcode == 3'b101) && (op == 2'b01);
  assign w_is_alu3    = (opcode == 3'b101) && (op != 2'b11);

  // MOV-reg and MVN route only Rm through the ALU, so A is forced to zero.
  // The choice is captured at DECODE so asel stays a function of registered state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_WAIT;
      r_zero_a <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == S_DECODE) r_zero_a <= w_is_mov_reg || w_is_mvn;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_WAIT: begin
        if (s) w_next = S_DECODE;
      end
      S_DECODE: begin
        if (w_is_mov_imm)                 w_next = S_WRITE_IMM;
        else if (w_is_mov_reg || w_is_mvn) w_next = S_GET_B;
        else if (w_is_alu3)               w_next = S_GET_A;
        else                              w_next = S_ERR;
      end
      S_GET_A:     w_next = S_GET_B;
      S_GET_B:     w_next = w_is_cmp ? S_CMP : S_ALU;
      S_ALU:       w_next = S_WRITE_REG;
      S_WRITE_REG: w_next = S_WAIT;
      S_WRITE_IMM: w_next = S_WAIT;
      S_CMP:       w_next = S_WAIT;
      S_ERR:       w_next = S_WAIT;
      default:     w_next = S_WAIT;
    endcase
  end

  always_comb begin
    w     = 1'b0;
    nsel  = 3'b000;
    loada = 1'b0;
    loadb = 1'b0;
    loadc = 1'b0;
    loads = 1'b0;
    asel  = 1'b0;
    bsel  = 1'b0;
    vsel  = VSEL_C;
    write = 1'b0;
    err   = 1'b0;
    case (r_state)
      S_WAIT:  w = 1'b1;
      S_GET_A: begin
        nsel  = 3'b100;
        loada = 1'b1;
      end
      S_GET_B: begin
        nsel  = 3'b001;
        loadb = 1'b1;
      end
      S_ALU: begin
        asel  = r_zero_a;
        loadc = 1'b1;
      end
      S_CMP:   loads = 1'b1;
      S_WRITE_REG: begin
        nsel  = 3'b010;
        vsel  = VSEL_C;
        write = 1'b1;
      end
      S_WRITE_IMM: begin
        nsel  = 3'b100;
        vsel  = VSEL_IMM;
        write = 1'b1;
      end
      S_ERR:   err = 1'b1;
      default: ;
    endcase
  end

  assign dbg_state         = r_state;
  // Writeback from PC or mdata belongs to other controllers; this flag should never rise here.
  assign dbg_vsel_reserved = (vsel == VSEL_PC) || (vsel == VSEL_MDATA);

endmodule

// File: tb/tb_cpu_controller_fsm.sv
// Bench for cpu_controller_fsm: latency/write table, micro-op sequence model with random
// instructions, back-to-back issue, illegal opcodes and asynchronous reset mid-instruction.
module tb_cpu_controller_fsm;
  localparam int W = 14;

  logic       clk;
  logic       reset;
  logic       s;
  logic [2:0] opcode;
  logic [1:0] op;
  logic       w;
  logic [2:0] nsel;
  logic       loada, loadb, loadc, loads, asel, bsel;
  logic [1:0] vsel;
  logic       write, err;
  logic [3:0] dbg_state;
  logic       dbg_vsel_reserved;

  cpu_controller_fsm dut (
    .clk(clk), .reset(reset), .s(s), .opcode(opcode), .op(op),
    .w(w), .nsel(nsel), .loada(loada), .loadb(loadb), .loadc(loadc),
    .loads(loads), .asel(asel), .bsel(bsel), .vsel(vsel), .write(write),
    .err(err), .dbg_state(dbg_state), .dbg_vsel_reserved(dbg_vsel_reserved)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;
  int write_total = 0;
  logic [W-1:0] exp_q[$];

  always @(negedge clk) if (write === 1'b1) write_total++;

  function automatic logic [W-1:0] act_vec();
    return {w, nsel, loada, loadb, loadc, loads, asel, bsel, vsel, write, err};
  endfunction

  function automatic logic [W-1:0] mk(input logic wi, input logic [2:0] ns,
                                      input logic la, input logic lb, input logic lc,
                                      input logic ls, input logic as_,
                                      input logic [1:0] vs, input logic wr, input logic er);
    return {wi, ns, la, lb, lc, ls, as_, 1'b0, vs, wr, er};
  endfunction

  function automatic logic [W-1:0] v_wait();
    return mk(1'b1, 3'b000, 0, 0, 0, 0, 0, 2'b00, 0, 0);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: an instruction is a list of micro-ops, one per cycle after WAIT.
  task automatic build_seq(input logic [2:0] opc, input logic [1:0] o);
    logic [W-1:0] idle, get_a, get_b, wreg;
    idle  = '0;
    get_a = mk(0, 3'b100, 1, 0, 0, 0, 0, 2'b00, 0, 0);
    get_b = mk(0, 3'b001, 0, 1, 0, 0, 0, 2'b00, 0, 0);
    wreg  = mk(0, 3'b010, 0, 0, 0, 0, 0, 2'b00, 1, 0);
    exp_q.delete();
    exp_q.push_back(idle);
    if (opc == 3'd6 && o == 2'd2) begin
      exp_q.push_back(mk(0, 3'b100, 0, 0, 0, 0, 0, 2'b10, 1, 0));
    end else if ((opc == 3'd6 && o == 2'd0) || (opc == 3'd5 && o == 2'd3)) begin
      exp_q.push_back(get_b);
      exp_q.push_back(mk(0, 3'b000, 0, 0, 1, 0, 1, 2'b00, 0, 0));
      exp_q.push_back(wreg);
    end else if (opc == 3'd5 && o == 2'd1) begin
      exp_q.push_back(get_a);
      exp_q.push_back(get_b);
      exp_q.push_back(mk(0, 3'b000, 0, 0, 0, 1, 0, 2'b00, 0, 0));
    end else if (opc == 3'd5) begin
      exp_q.push_back(get_a);
      exp_q.push_back(get_b);
      exp_q.push_back(mk(0, 3'b000, 0, 0, 1, 0, 0, 2'b00, 0, 0));
      exp_q.push_back(wreg);
    end else begin
      exp_q.push_back(mk(0, 3'b000, 0, 0, 0, 0, 0, 2'b00, 0, 1));
    end
  endtask

  // driver: called at a negedge while in WAIT; returns at the negedge of the next WAIT
  task automatic run_model_instr(input logic [2:0] opc, input logic [1:0] o,
                                 input bit keep_s, input string tag);
    logic [W-1:0] e;
    int step;
    check({tag, "_wait_before"}, act_vec(), v_wait());
    build_seq(opc, o);
    opcode = opc;
    op     = o;
    s      = 1'b1;
    step   = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      @(negedge clk);
      if (!keep_s) s = 1'b0;
      check($sformatf("%s_step%0d", tag, step), act_vec(), e);
      step++;
    end
    @(negedge clk);
  endtask

  typedef struct {
    logic [2:0] opc;
    logic [1:0] op;
    int         lat;
    int         writes;
    int         errs;
  } vec_t;
  vec_t tbl[10];

  task automatic run_table_entry(input int idx);
    int edges, writes, errs;
    bit done;
    opcode = tbl[idx].opc;
    op     = tbl[idx].op;
    s      = 1'b1;
    edges = 0; writes = 0; errs = 0; done = 0;
    while (!done && edges < 12) begin
      @(posedge clk);
      edges++;
      #1;
      s = 1'b0;
      if (write) writes++;
      if (err) errs++;
      if (w) done = 1;
    end
    check($sformatf("tbl%0d_latency", idx), edges, tbl[idx].lat);
    check($sformatf("tbl%0d_writes", idx), writes, tbl[idx].writes);
    check($sformatf("tbl%0d_errs", idx), errs, tbl[idx].errs);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int wt0;
    logic [2:0] ropc;
    logic [1:0] rop;
    bit rkeep;

    tbl[0] = '{3'b110, 2'b10, 3, 1, 0};
    tbl[1] = '{3'b110, 2'b00, 5, 1, 0};
    tbl[2] = '{3'b101, 2'b11, 5, 1, 0};
    tbl[3] = '{3'b101, 2'b00, 6, 1, 0};
    tbl[4] = '{3'b101, 2'b10, 6, 1, 0};
    tbl[5] = '{3'b101, 2'b01, 5, 0, 0};
    tbl[6] = '{3'b111, 2'b00, 3, 0, 1};
    tbl[7] = '{3'b000, 2'b00, 3, 0, 1};
    tbl[8] = '{3'b110, 2'b01, 3, 0, 1};
    tbl[9] = '{3'b110, 2'b11, 3, 0, 1};

    reset = 1'b1; s = 1'b0; opcode = 3'b000; op = 2'b00;
    repeat (3) begin
      @(negedge clk);
      check("reset_hold", act_vec(), v_wait());
    end
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check($sformatf("idle%0d", i), act_vec(), v_wait());
    end

    for (int i = 0; i < 10; i++) run_table_entry(i);

    // MOV R3,#-5 then ADD and CMP through the cycle-level model
    run_model_instr(3'b110, 2'b10, 0, "movimm");
    run_model_instr(3'b101, 2'b00, 0, "add");
    run_model_instr(3'b101, 2'b01, 0, "cmp");

    // back-to-back with s held high: no bubble, asel set in both ALU cycles, two writes
    wt0 = write_total;
    run_model_instr(3'b110, 2'b00, 1, "b2b_movr");
    run_model_instr(3'b101, 2'b11, 1, "b2b_mvn");
    s = 1'b0;
    check("b2b_writes", write_total - wt0, 2);
    check("b2b_wait_after", act_vec(), v_wait());

    // illegal opcode inside the model flow
    run_model_instr(3'b111, 2'b10, 0, "illegal");

    // reset asserted during GET_B of an ADD
    wt0 = write_total;
    opcode = 3'b101; op = 2'b00; s = 1'b1;
    @(negedge clk); s = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_mid_getb", act_vec(), mk(0, 3'b001, 0, 1, 0, 0, 0, 2'b00, 0, 0));
    #2 reset = 1'b1;
    #1 check("rst_mid_async", act_vec(), v_wait());
    repeat (3) begin
      @(negedge clk);
      check("rst_mid_hold", act_vec(), v_wait());
    end
    reset = 1'b0;
    repeat (4) begin
      @(negedge clk);
      check("rst_mid_after", act_vec(), v_wait());
    end
    check("rst_mid_no_write", write_total - wt0, 0);

    // random instructions, mostly legal, random s holding
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) != 0) begin
        ropc = ($urandom_range(0, 1) == 0) ? 3'b101 : 3'b110;
      end else begin
        ropc = 3'($urandom_range(0, 7));
      end
      rop   = 2'($urandom_range(0, 3));
      rkeep = 1'($urandom_range(0, 1));
      run_model_instr(ropc, rop, rkeep, $sformatf("rnd%0d", i));
    end
    s = 1'b0;
    check("end_wait", act_vec(), v_wait());
    check("vsel_reserved", dbg_vsel_reserved, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
